// File: rtl/aq_djpeg_mcu_seq.sv
// MCU sequencer: walks (component, v, h) block order for arbitrary sampling factors
// and queues one {X, Y, last} record per finished MCU into a small valid/ready FIFO.
module aq_djpeg_mcu_seq #(
  parameter int MAX_COMP = 4,
  parameter int SAMP_W   = 3,
  parameter int XY_W     = 12,
  parameter int FIFO_AW  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       Init,
  input  logic [2:0]                 NumComp,
  input  logic [MAX_COMP*SAMP_W-1:0] SampH,
  input  logic [MAX_COMP*SAMP_W-1:0] SampV,
  input  logic [XY_W-1:0]            McuWidth,
  input  logic [XY_W-1:0]            McuHeight,
  input  logic                       BlockDone,
  output logic                       InFull,
  output logic [2:0]                 CurComp,
  output logic [SAMP_W-1:0]          CurSubH,
  output logic [SAMP_W-1:0]          CurSubV,
  output logic                       McuOutValid,
  input  logic                       McuOutReady,
  output logic [XY_W-1:0]            McuOutX,
  output logic [XY_W-1:0]            McuOutY,
  output logic                       McuOutLast,
  output logic                       FrameDone,
  output logic                       Overflow
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef struct packed {
    logic [XY_W-1:0] x;
    logic [XY_W-1:0] y;
    logic            last;
  } rec_t;

  logic [2:0]         comp_q, comp_d;
  logic [SAMP_W-1:0]  subh_q, subh_d, subv_q, subv_d;
  logic [XY_W-1:0]    mcux_q, mcux_d, mcuy_q, mcuy_d;
  logic               frame_done_q, frame_done_d;
  logic               overflow_q, overflow_d;
  logic               infull_q, infull_d;
  logic               pend_q, pend_d;
  rec_t               pend_rec_q, pend_rec_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [FIFO_AW-1:0] wr_q, wr_d, rd_q, rd_d;
  rec_t               mem [DEPTH];

  logic [2:0]        nc_eff;
  logic [SAMP_W-1:0] h_raw, v_raw, h_eff, v_eff;
  logic [XY_W-1:0]   w_eff, hgt_eff;
  logic              accept, pop, mcu_done, row_end, is_last;

  always_comb begin
    nc_eff = NumComp;
    if (NumComp == 3'd0) nc_eff = 3'd1;
    else if (int'(NumComp) > MAX_COMP) nc_eff = 3'(MAX_COMP);
    h_raw = '0;
    v_raw = '0;
    for (int c = 0; c < MAX_COMP; c++) begin
      if (comp_q == 3'(c)) begin
        h_raw = SampH[c*SAMP_W +: SAMP_W];
        v_raw = SampV[c*SAMP_W +: SAMP_W];
      end
    end
    // Grayscale always scans one block per MCU, whatever the factor fields say.
    h_eff   = (nc_eff == 3'd1 || h_raw == '0) ? SAMP_W'(1) : h_raw;
    v_eff   = (nc_eff == 3'd1 || v_raw == '0) ? SAMP_W'(1) : v_raw;
    w_eff   = (McuWidth  == '0) ? XY_W'(1) : McuWidth;
    hgt_eff = (McuHeight == '0) ? XY_W'(1) : McuHeight;
    row_end = (mcux_q == w_eff - XY_W'(1));
    is_last = row_end && (mcuy_q == hgt_eff - XY_W'(1));
  end

  always_comb begin
    comp_d       = comp_q;
    subh_d       = subh_q;
    subv_d       = subv_q;
    mcux_d       = mcux_q;
    mcuy_d       = mcuy_q;
    frame_done_d = frame_done_q;
    overflow_d   = overflow_q;
    pend_rec_d   = pend_rec_q;
    mcu_done     = 1'b0;
    accept       = BlockDone && !infull_q && !frame_done_q;
    pop          = (count_q != '0) && McuOutReady;

    if (BlockDone && !accept) overflow_d = 1'b1;

    if (accept) begin
      if (subh_q != h_eff - SAMP_W'(1)) begin
        subh_d = subh_q + SAMP_W'(1);
      end else begin
        subh_d = '0;
        if (subv_q != v_eff - SAMP_W'(1)) begin
          subv_d = subv_q + SAMP_W'(1);
        end else begin
          subv_d = '0;
          if (comp_q != nc_eff - 3'd1) begin
            comp_d = comp_q + 3'd1;
          end else begin
            comp_d     = '0;
            mcu_done   = 1'b1;
            pend_rec_d = '{x: mcux_q, y: mcuy_q, last: is_last};
            if (is_last) begin
              frame_done_d = 1'b1;
            end else if (row_end) begin
              mcux_d = '0;
              mcuy_d = mcuy_q + XY_W'(1);
            end else begin
              mcux_d = mcux_q + XY_W'(1);
            end
          end
        end
      end
    end

    // The staged record lands one edge later; fullness counts it so nothing is lost.
    pend_d   = mcu_done;
    count_d  = count_q + {{FIFO_AW{1'b0}}, pend_q} - {{FIFO_AW{1'b0}}, pop};
    wr_d     = wr_q + FIFO_AW'(pend_q);
    rd_d     = rd_q + FIFO_AW'(pop);
    infull_d = ((count_d + {{FIFO_AW{1'b0}}, mcu_done}) == (FIFO_AW+1)'(DEPTH));

    if (Init) begin
      comp_d       = '0;
      subh_d       = '0;
      subv_d       = '0;
      mcux_d       = '0;
      mcuy_d       = '0;
      frame_done_d = 1'b0;
      overflow_d   = 1'b0;
      pend_d       = 1'b0;
      pend_rec_d   = '0;
      count_d      = '0;
      wr_d         = '0;
      rd_d         = '0;
      infull_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      comp_q       <= '0;
      subh_q       <= '0;
      subv_q       <= '0;
      mcux_q       <= '0;
      mcuy_q       <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      infull_q     <= 1'b0;
      pend_q       <= 1'b0;
      pend_rec_q   <= '0;
      count_q      <= '0;
      wr_q         <= '0;
      rd_q         <= '0;
    end else begin
      comp_q       <= comp_d;
      subh_q       <= subh_d;
      subv_q       <= subv_d;
      mcux_q       <= mcux_d;
      mcuy_q       <= mcuy_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
      infull_q     <= infull_d;
      pend_q       <= pend_d;
      pend_rec_q   <= pend_rec_d;
      count_q      <= count_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pend_q) mem[wr_q] <= pend_rec_q;
  end

  // Head fields are masked while empty so storage needs no reset.
  assign McuOutValid = (count_q != '0);
  assign McuOutX     = McuOutValid ? mem[rd_q].x : '0;
  assign McuOutY     = McuOutValid ? mem[rd_q].y : '0;
  assign McuOutLast  = McuOutValid ? mem[rd_q].last : 1'b0;
  assign InFull      = infull_q;
  assign CurComp     = comp_q;
  assign CurSubH     = subh_q;
  assign CurSubV     = subv_q;
  assign FrameDone   = frame_done_q;
  assign Overflow    = overflow_q;

endmodule
